e203_exu_wbck_arb: RTL and testbench
====================================

// Module: e203_exu_wbck_arb
// PURPOSE
//  Writeback arbiter driving the general-purpose register file write port.
//  Merges single-cycle ALU results with out-of-order long-pipe results (LSU/MulDiv),
//  buffering long-pipe results in a small FIFO. Drives the registered regfile write
//  strobe/index/data, one write per cycle. The ALU has priority, bounded by an anti-starvation counter.
// PARAMETERS
//  XLEN        32  data width of the register file
//  RFIDX_W     5   register index width
//  LP_DEPTH    2   long-pipe buffer entries (>=1)
//  STARVE_MAX  4   consecutive ALU wins allowed while buffer non-empty (>=1)
// PORTS
//  clk                 in   1        core clock
//  rst_n               in   1        asynchronous active-low reset
//  alu_wbck_i_valid    in   1        ALU result valid
//  alu_wbck_i_ready    out  1        ALU result accepted this cycle
//  alu_wbck_i_wdat     in   XLEN     ALU result data
//  alu_wbck_i_rdidx    in   RFIDX_W  ALU destination register
//  longp_wbck_i_valid  in   1        long-pipe result valid
//  longp_wbck_i_ready  out  1        long-pipe result accepted (buffer not full)
//  longp_wbck_i_wdat   in   XLEN     long-pipe result data
//  longp_wbck_i_rdidx  in   RFIDX_W  long-pipe destination register
//  rf_wbck_o_ena       out  1        regfile write enable (registered)
//  rf_wbck_o_rdidx     out  RFIDX_W  regfile write index (registered)
//  rf_wbck_o_wdat      out  XLEN     regfile write data (registered)
//  lp_buf_cnt          out  clog2(LP_DEPTH+1)  buffer occupancy
//  lp_buf_empty        out  1        buffer empty
// BEHAVIOUR
//  - Reset (async, rst_n=0): buffer empty, occupancy 0, starve counter 0,
//    rf_wbck_o_ena=0, rf_wbck_o_rdidx=0, rf_wbck_o_wdat=0.
//  - Long-pipe push: longp_wbck_i_ready = !full (depends only on the registered
//    occupancy; no combinational path from a same-cycle pop). A push occurs when
//    valid & ready. The entry is visible at the buffer head the next cycle; there is no bypass.
//  - Arbitration each cycle between the ALU request and the buffer head (non-empty):
//    * starve_cnt < STARVE_MAX: the ALU wins if alu valid, else the buffer head wins.
//    * starve_cnt == STARVE_MAX: the buffer head wins; alu_wbck_i_ready=0 this cycle.
//    * alu_wbck_i_ready=1 whenever the ALU wins, or when the buffer is empty.
//  - starve_cnt: +1 when the buffer is non-empty and the ALU wins; cleared on a buffer
//    pop or when the buffer is empty; saturates at STARVE_MAX.
//  - The winner's idx/data register into the rf_wbck_o_* outputs on the next edge.
//    rf_wbck_o_ena=1 for exactly one cycle per accepted result, except rdidx==0, where
//    ena stays 0: the write to x0 is dropped but the result is still consumed or popped.
//  - With no winner, rf_wbck_o_ena=0 and idx/data hold their previous values.
//  - Latency: ALU accept at cycle N -> write at N+1; long-pipe push at N -> earliest write at N+2.
//  - Push and pop in the same cycle: occupancy unchanged; pointers wrap modulo LP_DEPTH.
//  - Buffer order is strict FIFO; entries are never reordered or dropped except by reset.
//  - Reset mid-operation discards buffered entries; no write is issued after reset release
//    until a new valid handshake occurs.
// TESTING
//  1. ALU only: valid, idx=5, dat=0x0000_1234 at cyc0 -> ready=1 at cyc0;
//     ena=1, idx=5, dat=0x1234 at cyc1; ena=0 at cyc2.
//  2. Long-pipe only: push idx=3, dat=0xA5A5_A5A5 at cyc0 -> lp_buf_cnt=1 at cyc1;
//     ena=1, idx=3 at cyc2; buffer empty at cyc2.
//  3. Starvation: ALU valid continuously, one long-pipe push at cyc0 -> ALU writes
//     cyc2..5; at cyc5 alu_ready=0 and the buffer wins; long-pipe data written at cyc6;
//     ALU resumes at cyc7.
//  4. Full: 3 back-to-back pushes while the ALU holds the port -> longp_ready=0 on the
//     third (LP_DEPTH=2); data is retained and later written in FIFO order.
//  5. x0: ALU idx=0, dat=0xFFFF_FFFF -> ready=1 and ena never asserts; the same for a
//     long-pipe entry with idx=0, which is popped without a write.
//  6. Reset with 2 buffered entries -> lp_buf_cnt=0, lp_buf_empty=1, ena=0 immediately;
//     no stale write after release.

Source files
------------

// File: rtl/e203_exu_wbck_arb.sv
// Writeback arbiter for the integer register file write port.
// Merges single-cycle ALU results with long-pipe (LSU/MulDiv) results.
// Long-pipe results wait in a small FIFO. The ALU normally has priority.
// An anti-starvation counter forces the FIFO head through after STARVE_MAX
// consecutive ALU wins while the FIFO holds data.
//
// Handshake rule used on both input channels: a transfer happens on a rising
// clock edge when valid and ready are both high in that cycle. Ready never
// depends on valid from the same channel. Once valid is raised, the producer
// holds data/index steady until the transfer.
module e203_exu_wbck_arb #(
  parameter  int XLEN       = 32,
  parameter  int RFIDX_W    = 5,
  parameter  int LP_DEPTH   = 2,
  parameter  int STARVE_MAX = 4,
  localparam int CNT_W      = $clog2(LP_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [XLEN-1:0]    alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
  input  logic               longp_wbck_i_valid,
  output logic               longp_wbck_i_ready,
  input  logic [XLEN-1:0]    longp_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
  output logic               rf_wbck_o_ena,
  output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,
  output logic [XLEN-1:0]    rf_wbck_o_wdat,
  output logic [CNT_W-1:0]   lp_buf_cnt,
  output logic               lp_buf_empty
);

  localparam int PTR_W = (LP_DEPTH > 1) ? $clog2(LP_DEPTH) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  logic [XLEN-1:0]    buf_dat [LP_DEPTH];
  logic [RFIDX_W-1:0] buf_idx [LP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [STV_W-1:0]   starve_cnt;

  logic               full, empty, starved;
  logic               alu_win, buf_win, push, pop;
  logic [RFIDX_W-1:0] sel_idx;
  logic [XLEN-1:0]    sel_dat;

  // Pointers wrap at LP_DEPTH so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(LP_DEPTH - 1)) return '0;
    else return p + 1'b1;
  endfunction

  // Arbitration and handshake decode. Ready depends only on registered state.
  always_comb begin
    full               = (cnt == CNT_W'(LP_DEPTH));
    empty              = (cnt == '0);
    starved            = (starve_cnt == STV_W'(STARVE_MAX));
    alu_wbck_i_ready   = empty | ~starved;
    longp_wbck_i_ready = ~full;
    alu_win            = alu_wbck_i_valid & alu_wbck_i_ready;
    buf_win            = ~empty & ~alu_win;
    push               = longp_wbck_i_valid & ~full;
    pop                = buf_win;
    sel_idx            = alu_win ? alu_wbck_i_rdidx : buf_idx[rd_ptr];
    sel_dat            = alu_win ? alu_wbck_i_wdat  : buf_dat[rd_ptr];
  end

  // FIFO storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_dat[wr_ptr] <= longp_wbck_i_wdat;
      buf_idx[wr_ptr] <= longp_wbck_i_rdidx;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // Count consecutive ALU wins over a waiting FIFO head; saturates at STARVE_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else if (alu_win && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Register the winner. A write to x0 is consumed but never strobed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wbck_o_ena   <= 1'b0;
      rf_wbck_o_rdidx <= '0;
      rf_wbck_o_wdat  <= '0;
    end else begin
      rf_wbck_o_ena <= (alu_win | buf_win) && (sel_idx != '0);
      if (alu_win | buf_win) begin
        rf_wbck_o_rdidx <= sel_idx;
        rf_wbck_o_wdat  <= sel_dat;
      end
    end
  end

  assign lp_buf_cnt   = cnt;
  assign lp_buf_empty = empty;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Directed bench for the writeback arbiter: a cycle table plus hand sequences.
module tb_e203_exu_wbck_arb;

  localparam int XLEN    = 32;
  localparam int RFIDX_W = 5;
  localparam int W       = RFIDX_W + XLEN;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               alu_valid = 1'b0;
  logic               alu_ready;
  logic [XLEN-1:0]    alu_wdat = '0;
  logic [RFIDX_W-1:0] alu_rdidx = '0;
  logic               lp_valid = 1'b0;
  logic               lp_ready;
  logic [XLEN-1:0]    lp_wdat = '0;
  logic [RFIDX_W-1:0] lp_rdidx = '0;
  logic               rf_ena;
  logic [RFIDX_W-1:0] rf_rdidx;
  logic [XLEN-1:0]    rf_wdat;
  logic [1:0]         buf_cnt;
  logic               buf_empty;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;
  logic [W-1:0] exp_q[$];

  e203_exu_wbck_arb dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .alu_wbck_i_valid   (alu_valid),
    .alu_wbck_i_ready   (alu_ready),
    .alu_wbck_i_wdat    (alu_wdat),
    .alu_wbck_i_rdidx   (alu_rdidx),
    .longp_wbck_i_valid (lp_valid),
    .longp_wbck_i_ready (lp_ready),
    .longp_wbck_i_wdat  (lp_wdat),
    .longp_wbck_i_rdidx (lp_rdidx),
    .rf_wbck_o_ena      (rf_ena),
    .rf_wbck_o_rdidx    (rf_rdidx),
    .rf_wbck_o_wdat     (rf_wdat),
    .lp_buf_cnt         (buf_cnt),
    .lp_buf_empty       (buf_empty)
  );

  // Clock and reset
  always #5 clk = ~clk;

  typedef struct {
    logic               av;
    logic [RFIDX_W-1:0] ai;
    logic [XLEN-1:0]    ad;
    logic               lv;
    logic [RFIDX_W-1:0] li;
    logic [XLEN-1:0]    ld;
    logic               ar;
    logic               lr;
    logic               ena;
    logic [RFIDX_W-1:0] idx;
    logic [XLEN-1:0]    dat;
    int                 cnt;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic av, input int ai, input logic [31:0] ad,
                              input logic lv, input int li, input logic [31:0] ld,
                              input logic ar, input logic lr, input logic ena,
                              input int idx, input logic [31:0] dat, input int cnt);
    vec_t v;
    v.av = av; v.ai = RFIDX_W'(ai); v.ad = ad;
    v.lv = lv; v.li = RFIDX_W'(li); v.ld = ld;
    v.ar = ar; v.lr = lr; v.ena = ena;
    v.idx = RFIDX_W'(idx); v.dat = dat; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic av, input int ai, input logic [31:0] ad,
                       input logic lv, input int li, input logic [31:0] ld);
    alu_valid = av; alu_rdidx = RFIDX_W'(ai); alu_wdat = ad;
    lp_valid  = lv; lp_rdidx  = RFIDX_W'(li); lp_wdat  = ld;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    for (int k = 0; k < n; k++) next_cycle();
  endtask

  function automatic logic [W-1:0] wr(input int idx, input logic [31:0] dat);
    return {RFIDX_W'(idx), dat};
  endfunction

  // Scoreboard: every strobed write must match the head of exp_q.
  always @(negedge clk) begin
    if (mon_en && rf_ena) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got idx=%0d dat=%0h want no write", rf_rdidx, rf_wdat);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({rf_rdidx, rf_wdat} !== e) begin
          bad++;
          $display("FAIL wr_order: got idx=%0d dat=%0h want idx=%0d dat=%0h",
                   rf_rdidx, rf_wdat, e[W-1:XLEN], e[XLEN-1:0]);
        end
      end
    end
  end

  initial begin
    //             av ai  ad          lv li ld            ar lr ena idx dat         cnt
    // ALU only
    tbl[0]  = mk(1, 5, 32'h1234,     0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        0);
    tbl[1]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 1, 5, 32'h1234,     0);
    tbl[2]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        0);
    // Long-pipe only
    tbl[3]  = mk(0, 0, 32'h0,        1, 3, 32'hA5A5A5A5, 1, 1, 0, 0, 32'h0,        0);
    tbl[4]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        1);
    tbl[5]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 1, 3, 32'hA5A5A5A5, 0);
    // Starvation: ALU continuous, one push at cyc0
    tbl[6]  = mk(1, 7, 32'h10,       1, 9, 32'h99,       1, 1, 0, 0, 32'h0,        0);
    tbl[7]  = mk(1, 7, 32'h11,       0, 0, 32'h0,        1, 1, 1, 7, 32'h10,       1);
    tbl[8]  = mk(1, 7, 32'h12,       0, 0, 32'h0,        1, 1, 1, 7, 32'h11,       1);
    tbl[9]  = mk(1, 7, 32'h13,       0, 0, 32'h0,        1, 1, 1, 7, 32'h12,       1);
    tbl[10] = mk(1, 7, 32'h14,       0, 0, 32'h0,        1, 1, 1, 7, 32'h13,       1);
    tbl[11] = mk(1, 7, 32'h15,       0, 0, 32'h0,        0, 1, 1, 7, 32'h14,       1);
    tbl[12] = mk(1, 7, 32'h15,       0, 0, 32'h0,        1, 1, 1, 9, 32'h99,       0);
    tbl[13] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 1, 7, 32'h15,       0);
    tbl[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 0, 32'h0,        0);

    // Reset state
    #3;
    check("rst_ena", 64'(rf_ena), 64'(0));
    check("rst_idx", 64'(rf_rdidx), 64'(0));
    check("rst_dat", 64'(rf_wdat), 64'(0));
    check("rst_cnt", 64'(buf_cnt), 64'(0));
    check("rst_empty", 64'(buf_empty), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    next_cycle();

    // Table-driven cycles
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].av, int'(tbl[i].ai), tbl[i].ad, tbl[i].lv, int'(tbl[i].li), tbl[i].ld);
      check($sformatf("row%0d_alu_rdy", i), 64'(alu_ready), 64'(tbl[i].ar));
      check($sformatf("row%0d_lp_rdy", i), 64'(lp_ready), 64'(tbl[i].lr));
      check($sformatf("row%0d_ena", i), 64'(rf_ena), 64'(tbl[i].ena));
      check($sformatf("row%0d_cnt", i), 64'(buf_cnt), 64'(tbl[i].cnt));
      check($sformatf("row%0d_empty", i), 64'(buf_empty), 64'(tbl[i].cnt == 0));
      if (tbl[i].ena) begin
        check($sformatf("row%0d_idx", i), 64'(rf_rdidx), 64'(tbl[i].idx));
        check($sformatf("row%0d_dat", i), 64'(rf_wdat), 64'(tbl[i].dat));
      end
      next_cycle();
    end

    mon_en = 1'b1;

    // Full buffer while the ALU holds the port
    exp_q.push_back(wr(2, 32'h20)); exp_q.push_back(wr(2, 32'h21));
    exp_q.push_back(wr(2, 32'h22)); exp_q.push_back(wr(2, 32'h23));
    exp_q.push_back(wr(2, 32'h24)); exp_q.push_back(wr(10, 32'hA));
    exp_q.push_back(wr(2, 32'h25)); exp_q.push_back(wr(11, 32'hB));
    exp_q.push_back(wr(12, 32'hC));
    drive(1'b1, 2, 32'h20, 1'b1, 10, 32'hA); check("full_c0_lp_rdy", 64'(lp_ready), 64'(1)); next_cycle();
    drive(1'b1, 2, 32'h21, 1'b1, 11, 32'hB); check("full_c1_lp_rdy", 64'(lp_ready), 64'(1)); next_cycle();
    drive(1'b1, 2, 32'h22, 1'b1, 12, 32'hC); check("full_c2_lp_rdy", 64'(lp_ready), 64'(0));
    check("full_c2_cnt", 64'(buf_cnt), 64'(2)); next_cycle();
    drive(1'b1, 2, 32'h23, 1'b1, 12, 32'hC); check("full_c3_lp_rdy", 64'(lp_ready), 64'(0)); next_cycle();
    drive(1'b1, 2, 32'h24, 1'b1, 12, 32'hC); check("full_c4_alu_rdy", 64'(alu_ready), 64'(1)); next_cycle();
    drive(1'b1, 2, 32'h25, 1'b1, 12, 32'hC); check("full_c5_alu_rdy", 64'(alu_ready), 64'(0));
    check("full_c5_lp_rdy", 64'(lp_ready), 64'(0)); next_cycle();
    drive(1'b1, 2, 32'h25, 1'b1, 12, 32'hC); check("full_c6_lp_rdy", 64'(lp_ready), 64'(1));
    check("full_c6_cnt", 64'(buf_cnt), 64'(1)); next_cycle();
    idle(6);
    check("full_drained", 64'(exp_q.size()), 64'(0));
    check("full_cnt_end", 64'(buf_cnt), 64'(0));

    // Writes to x0 are consumed without a strobe
    drive(1'b1, 0, 32'hFFFFFFFF, 1'b0, 0, 32'h0); check("x0_alu_rdy", 64'(alu_ready), 64'(1)); next_cycle();
    drive(1'b0, 0, 32'h0, 1'b1, 0, 32'h55); check("x0_lp_rdy", 64'(lp_ready), 64'(1)); next_cycle();
    drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0); check("x0_cnt1", 64'(buf_cnt), 64'(1)); next_cycle();
    check("x0_cnt0", 64'(buf_cnt), 64'(0));
    check("x0_empty", 64'(buf_empty), 64'(1));
    check("x0_no_ena", 64'(rf_ena), 64'(0));
    idle(2);

    // Reset with two buffered entries
    exp_q.push_back(wr(4, 32'h40)); exp_q.push_back(wr(4, 32'h41));
    drive(1'b1, 4, 32'h40, 1'b1, 13, 32'hD); next_cycle();
    drive(1'b1, 4, 32'h41, 1'b1, 14, 32'hE); next_cycle();
    drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    check("rst2_cnt_before", 64'(buf_cnt), 64'(2));
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst2_cnt", 64'(buf_cnt), 64'(0));
    check("rst2_empty", 64'(buf_empty), 64'(1));
    check("rst2_ena", 64'(rf_ena), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(5);
    check("rst2_queue", 64'(exp_q.size()), 64'(0));
    check("rst2_cnt_after", 64'(buf_cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global timeout guard
  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
